// File: rtl/wb_prefetch_fifo.sv
// Prefetch FIFO: a Wishbone classic controller polls a source device for words
// and buffers them; a Wishbone classic device port lets a consumer pop them.
module wb_prefetch_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  output logic                  src_cyc_o,
  output logic                  src_stb_o,
  output logic                  src_we_o,
  input  logic [DATA_WIDTH-1:0] src_dat_i,
  input  logic                  src_ack_i,
  input  logic                  snk_cyc_i,
  input  logic                  snk_stb_i,
  input  logic                  snk_we_i,
  output logic [DATA_WIDTH-1:0] snk_dat_o,
  output logic                  snk_ack_o,
  output logic                  snk_err_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_READ = 1'b1;

  logic                  state_q, state_d;
  logic                  src_cyc_q, src_cyc_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  snk_ack_q, snk_ack_d;
  logic                  snk_err_q, snk_err_d;
  logic [DATA_WIDTH-1:0] snk_dat_q, snk_dat_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, req, capture, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // The ack/err cycle masks the request so one bus read yields one pop.
  assign req     = snk_cyc_i && snk_stb_i && !snk_ack_q && !snk_err_q;
  assign capture = (state_q == ST_READ) && src_ack_i;
  assign pop     = req && !snk_we_i && !empty;

  always_comb begin
    state_d   = state_q;
    src_cyc_d = src_cyc_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_en_i && !full) begin
          state_d   = ST_READ;
          src_cyc_d = 1'b1;
        end
      end
      ST_READ: begin
        if (src_ack_i) begin
          state_d   = ST_IDLE;
          src_cyc_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        src_cyc_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    snk_ack_d = pop;
    snk_err_d = req && snk_we_i;
    snk_dat_d = pop ? mem_q[rd_ptr_q] : snk_dat_q;
    // A read is only launched when not full, so capture can never overflow.
    case ({capture, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      src_cyc_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      snk_ack_q <= 1'b0;
      snk_err_q <= 1'b0;
      snk_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      src_cyc_q <= src_cyc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      snk_ack_q <= snk_ack_d;
      snk_err_q <= snk_err_d;
      snk_dat_q <= snk_dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && capture) begin
      mem_q[wr_ptr_q] <= src_dat_i;
    end
  end

  assign src_cyc_o = src_cyc_q;
  assign src_stb_o = src_cyc_q;
  assign src_we_o  = 1'b0;
  assign snk_dat_o = snk_dat_q;
  assign snk_ack_o = snk_ack_q;
  assign snk_err_o = snk_err_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_wb_prefetch_fifo.sv
// Directed bench for wb_prefetch_fifo: a background source responder feeds a
// numbered word stream, the initial block drives the sink port and checks.
module tb_wb_prefetch_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       fetch_en_i = 1'b0;
  logic       src_cyc_o, src_stb_o, src_we_o;
  logic [7:0] src_dat_i = 8'h00;
  logic       src_ack_i = 1'b0;
  logic       snk_cyc_i = 1'b0;
  logic       snk_stb_i = 1'b0;
  logic       snk_we_i = 1'b0;
  logic [7:0] snk_dat_o;
  logic       snk_ack_o, snk_err_o;
  logic [4:0] count_o;

  wb_prefetch_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_en_i(fetch_en_i),
    .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
    .src_dat_i(src_dat_i), .src_ack_i(src_ack_i),
    .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
    .snk_dat_o(snk_dat_o), .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int fails = 0;

  // Responder controls (written only by the initial block)
  bit         resp_en = 1'b0;
  int         resp_wait = 0;
  logic [7:0] seed = 8'h00;
  int         seed_gen = 0;
  bit         inj_ack = 1'b0;

  // Responder / monitor state (written only by the always blocks)
  logic [7:0] nxt = 8'h00;
  int         last_gen = 0;
  int         wait_cnt = 0;
  int         cyc_n = 0;
  int         rises = 0;
  logic       cyc_prev = 1'b0;

  // Checker state touched only from the initial block
  int         first_cnt = -1;
  bit         saw_simul = 1'b0;

  always @(posedge clk_i) cyc_n++;

  always @(posedge clk_i) begin
    #2;
    if (src_cyc_o && !cyc_prev) rises++;
    cyc_prev = src_cyc_o;
  end

  // Source device: acks each read after resp_wait cycles with the next number.
  always @(posedge clk_i) begin
    #1;
    if (seed_gen != last_gen) begin
      nxt      = seed;
      last_gen = seed_gen;
    end
    if (!resp_en) begin
      wait_cnt  = 0;
      src_ack_i = inj_ack;
      if (inj_ack) src_dat_i = 8'hEE;
    end else if (src_ack_i) begin
      src_ack_i = 1'b0;
    end else if (src_cyc_o && src_stb_o) begin
      if (wait_cnt < resp_wait) begin
        wait_cnt++;
      end else begin
        src_ack_i = 1'b1;
        src_dat_i = nxt;
        nxt       = nxt + 8'h01;
        wait_cnt  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_seed(input logic [7:0] s);
    seed = s;
    seed_gen++;
  endtask

  // Pop one word; also checks the count update against capture/pop bookkeeping.
  task automatic sink_read(output logic [7:0] d, output int ack_cyc);
    int   prev_cnt;
    logic prev_cap;
    bit   got;
    got      = 1'b0;
    d        = 8'h00;
    ack_cyc  = -1;
    snk_cyc_i = 1'b1;
    snk_stb_i = 1'b1;
    snk_we_i  = 1'b0;
    prev_cnt = int'(count_o);
    prev_cap = src_cyc_o && src_ack_i;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (first_cnt < 0 && count_o != 5'd0) first_cnt = cyc_n;
      if (snk_ack_o) begin
        got     = 1'b1;
        d       = snk_dat_o;
        ack_cyc = cyc_n;
        check("pop_count", 32'(count_o), 32'(prev_cnt + int'(prev_cap) - 1));
        if (prev_cap) saw_simul = 1'b1;
      end
      prev_cnt = int'(count_o);
      prev_cap = src_cyc_o && src_ack_i;
    end
    snk_cyc_i = 1'b0;
    snk_stb_i = 1'b0;
    if (!got) check("pop_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    int         ac;
    int         base;
    bit         got;
    bit         cyc_while_full;

    repeat (3) tick();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_cyc", 32'({src_cyc_o, src_stb_o, src_we_o}), 32'd0);
    check("rst_snk", 32'({snk_ack_o, snk_err_o, snk_dat_o}), 32'd0);

    // Fill from reset: 16 reads of 0x00..0x0F, then stall while full
    rst_i = 1'b0;
    set_seed(8'h00);
    resp_en = 1'b1;
    resp_wait = 0;
    base = rises;
    fetch_en_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      if (count_o == 5'd16) got = 1'b1;
    end
    check("fill_reached", 32'(got), 32'd1);
    cyc_while_full = 1'b0;
    repeat (10) begin
      tick();
      if (src_cyc_o) cyc_while_full = 1'b1;
    end
    check("full_no_cyc", 32'(cyc_while_full), 32'd0);
    check("full_count", 32'(count_o), 32'd16);
    check("fill_cycles", 32'(rises - base), 32'd16);

    // One pop from full; refetch must follow within 2 cycles
    sink_read(d, ac);
    check("pop_first", 32'(d), 32'h00);
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      if (i == 0) begin
        check("ack_pulse", 32'(snk_ack_o), 32'd0);
        check("dat_hold", 32'(snk_dat_o), 32'h00);
      end
      if (src_cyc_o) got = 1'b1;
    end
    check("refetch", 32'(got), 32'd1);
    fetch_en_i = 1'b0;
    repeat (4) tick();
    check("refill_count", 32'(count_o), 32'd16);
    for (int i = 0; i < 16; i++) begin
      sink_read(d, ac);
      check("drain_seq", 32'(d), 32'(i + 1));
    end
    tick();
    check("drained", 32'(count_o), 32'd0);

    // Pending read on empty buffer, slow source answers 0xA5
    resp_wait = 3;
    set_seed(8'hA5);
    first_cnt = -1;
    fork
      sink_read(d, ac);
      begin
        tick();
        fetch_en_i = 1'b1;
        for (int i = 0; i < 10 && !src_cyc_o; i++) tick();
        fetch_en_i = 1'b0;
      end
    join
    check("pend_data", 32'(d), 32'hA5);
    check("pend_latency", 32'(ac - first_cnt), 32'd1);
    check("pend_count", 32'(count_o), 32'd0);

    // 40-word stream with concurrent pops; a 2-cycle gap realigns pops onto captures
    resp_wait = 0;
    set_seed(8'h40);
    saw_simul = 1'b0;
    fetch_en_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sink_read(d, ac);
      check("stream_seq", 32'(d), 32'(8'h40 + i));
      if (i == 5) repeat (2) tick();
    end
    check("stream_simul", 32'(saw_simul), 32'd1);
    repeat (40) tick();
    fetch_en_i = 1'b0;
    repeat (4) tick();
    check("stream_full", 32'(count_o), 32'd16);

    // Write request: error pulse only
    snk_cyc_i = 1'b1;
    snk_stb_i = 1'b1;
    snk_we_i  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      if (snk_err_o) begin
        got = 1'b1;
        check("wr_no_ack", 32'(snk_ack_o), 32'd0);
      end
    end
    snk_cyc_i = 1'b0;
    snk_stb_i = 1'b0;
    snk_we_i  = 1'b0;
    check("wr_err", 32'(got), 32'd1);
    tick();
    check("wr_err_pulse", 32'(snk_err_o), 32'd0);
    check("wr_count", 32'(count_o), 32'd16);
    sink_read(d, ac);
    check("wr_order", 32'(d), 32'h68);

    // Reset while a read is outstanding with 5 words buffered
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_seed(8'h10);
    resp_wait = 0;
    fetch_en_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (count_o == 5'd5) got = 1'b1;
    end
    resp_wait = 20;
    for (int i = 0; i < 4 && !src_cyc_o; i++) tick();
    check("mid_read", 32'({src_cyc_o, count_o}), 32'({1'b1, 5'd5}));
    fetch_en_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_cyc", 32'(src_cyc_o), 32'd0);
    check("rst_mid_count", 32'(count_o), 32'd0);
    resp_en = 1'b0;
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    tick();
    tick();
    check("late_ack_ignored", 32'(count_o), 32'd0);
    set_seed(8'h77);
    resp_en = 1'b1;
    fetch_en_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (count_o != 5'd0) got = 1'b1;
    end
    fetch_en_i = 1'b0;
    sink_read(d, ac);
    check("fresh_word", 32'(d), 32'h77);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/wb_prefetch_fifo.md
Name: wb_prefetch_fifo

Overview:
Read-side counterpart of the push FIFO. A Wishbone classic controller port issues read cycles to an upstream source device, such as a peripheral RX data register, and stores each returned byte in a circular buffer. A Wishbone classic device port lets a downstream controller pop buffered bytes with read cycles. The block sits between a polled data source and a consumer, decoupling source latency from consumer reads.

Parameters:
ADDR_WIDTH, 4, buffer address bits; DEPTH = 2**ADDR_WIDTH entries (16 by default)
DATA_WIDTH, 8, width of buffered data word

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
fetch_en_i  input  1  allow new source reads while high
src_cyc_o  output  1  source-side cycle
src_stb_o  output  1  source-side strobe
src_we_o  output  1  always 0 (read-only controller)
src_dat_i  input  DATA_WIDTH  read data from source device
src_ack_i  input  1  source acknowledge
snk_cyc_i  input  1  sink-side cycle from downstream controller
snk_stb_i  input  1  sink-side strobe
snk_we_i  input  1  write enable from downstream (writes are illegal)
snk_dat_o  output  DATA_WIDTH  popped data, valid while snk_ack_o is high
snk_ack_o  output  1  read acknowledge (one-cycle pulse)
snk_err_o  output  1  error response to write requests (one-cycle pulse)
count_o  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Single clock domain; all outputs registered.
- Reset: count_o=0, read/write pointers=0, fetch FSM=IDLE, src_cyc_o=src_stb_o=0, snk_ack_o=snk_err_o=0, snk_dat_o=0. Reset mid-read abandons the cycle; src_cyc_o is low the cycle after rst_i is sampled. A late src_ack_i is ignored.
- full = (count==DEPTH); empty = (count==0).
- Fetch FSM, IDLE:
  - If fetch_en_i && !full, go to READ.
  - src_cyc_o and src_stb_o go high on the next edge.
- Fetch FSM, READ:
  - Hold src_cyc_o and src_stb_o high until src_ack_i is sampled high.
  - On that edge: write src_dat_i to buf[wr_ptr], increment wr_ptr (wraps DEPTH-1 to 0), return to IDLE, and drop src_cyc_o and src_stb_o.
  - The minimum gap is one idle cycle between source reads, so throughput is at most 1 word per 2 cycles.
- Slot reservation: a read starts only if !full. Pops during READ can only free space, so the capture always fits and overflow is impossible.
- fetch_en_i low during READ: the in-flight read completes and no new read starts.
- src_ack_i in IDLE is ignored.
- Sink request: req = snk_cyc_i && snk_stb_i && !snk_ack_o && !snk_err_o.
- Sink read (req && !snk_we_i && !empty):
  - Next edge: snk_ack_o=1 for exactly one cycle and snk_dat_o=buf[rd_ptr].
  - Increment rd_ptr (wraps) and decrement count on the same edge.
- Sink read while empty: no ack; the request waits. The first cycle count>0 is sampled, the ack follows on the next edge. A word captured on edge N is acknowledged at the earliest on edge N+1.
- Sink write (req && snk_we_i): snk_err_o=1 for one cycle, no ack, no buffer or count change.
- Back-to-back sink reads are possible every 2 cycles, because the ack cycle masks req.
- Simultaneous capture and pop on one edge: count unchanged, both pointers advance.
- Count width ADDR_WIDTH+1 so it can represent DEPTH; no saturating arithmetic needed because the invariants prevent overflow and underflow.
- snk_dat_o holds its last value when snk_ack_o is low.

Test Plan:
- Reset then fetch_en_i=1, source acks every read with 0x00,0x01,...: count_o reaches 16, src_cyc_o stays low while full, exactly 16 source cycles are observed.
- Full buffer, downstream pops 1 word: snk_dat_o=0x00 with a one-cycle snk_ack_o, count_o goes 16→15, and a new source read starts within 2 cycles.
- Empty buffer, downstream read pending, source acks 0xA5 after a 3-cycle wait: snk_ack_o rises 1 cycle after count_o=1 is sampled, snk_dat_o=0xA5, count returns to 0.
- Steady stream of 40 words with concurrent pops (wraps pointers twice): output sequence equals input sequence; capture+pop on the same edge leaves count_o unchanged.
- Downstream write request (snk_we_i=1): one-cycle snk_err_o, no snk_ack_o, count_o and data order unaffected.
- rst_i asserted during READ with count_o=5: the next cycle has src_cyc_o=0 and count_o=0. A src_ack_i arriving after reset is ignored; the following read returns a fresh source word.
